prog_fetch_unit: RTL and testbench

- Reader side of the byte-wide program memory. Owns the program counter and drives the memory's chip select (active low) and address.
- Samples returned bytes and assembles complete MCS-51 instructions of 1–3 bytes.
- Hands each instruction to the decoder over a valid/ready handshake.
- Sits between the program ROM and the instruction decoder. Accepts jump redirects from the execute stage.

---
 rtl/mcs51_pkg.sv | 24 ++
 rtl/mcs51_len_lut.sv | 74 +++++++
 rtl/prog_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_prog_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs51_pkg.sv
// Shared MCS-51 fetch definitions: fetch state encoding, instruction length
// type and opcode constants used by the fetch unit and its testbench.
package mcs51_pkg;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 3'd0;
    localparam fetch_state_t ST_OP   = 3'd1;
    localparam fetch_state_t ST_B1   = 3'd2;
    localparam fetch_state_t ST_B2   = 3'd3;
    localparam fetch_state_t ST_HOLD = 3'd4;

    typedef logic [1:0] instr_len_t;

    localparam instr_len_t LEN1 = 2'd1;
    localparam instr_len_t LEN2 = 2'd2;
    localparam instr_len_t LEN3 = 2'd3;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_LJMP        = 8'h02;
    localparam logic [7:0] OP_MOV_A_IMM   = 8'h74;
    localparam logic [7:0] OP_MOV_DIR_IMM = 8'h75;

endpackage

// File: rtl/mcs51_len_lut.sv
// Combinational MCS-51 opcode -> instruction byte length (1..3), full map.
module mcs51_len_lut
    import mcs51_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic [1:0] o_len
);

    logic [3:0] w_hi;
    logic [3:0] w_lo;

    assign w_hi = i_opcode[7:4];
    assign w_lo = i_opcode[3:0];

    // Column x1 is AJMP/ACALL in every row; other columns decoded per row.
    always_comb begin
        o_len = LEN1;
        if (w_lo == 4'h1) begin
            o_len = LEN2;
        end else begin
            case (w_hi)
                4'h0: begin
                    if (w_lo == 4'h2)      o_len = LEN3;
                    else if (w_lo == 4'h5) o_len = LEN2;
                end
                4'h1: begin
                    if (w_lo == 4'h0 || w_lo == 4'h2) o_len = LEN3;
                    else if (w_lo == 4'h5)            o_len = LEN2;
                end
                4'h2, 4'h3: begin
                    if (w_lo == 4'h0)                      o_len = LEN3;
                    else if (w_lo == 4'h4 || w_lo == 4'h5) o_len = LEN2;
                end
                4'h4, 4'h5, 4'h6: begin
                    if (w_lo == 4'h3)                             o_len = LEN3;
                    else if (w_lo == 4'h0 || w_lo == 4'h2 ||
                             w_lo == 4'h4 || w_lo == 4'h5)        o_len = LEN2;
                end
                4'h7: begin
                    if (w_lo == 4'h5)      o_len = LEN3;
                    else if (w_lo != 4'h3) o_len = LEN2;
                end
                4'h8: begin
                    if (w_lo == 4'h5)                           o_len = LEN3;
                    else if (w_lo != 4'h3 && w_lo != 4'h4)      o_len = LEN2;
                end
                4'h9: begin
                    if (w_lo == 4'h0)                           o_len = LEN3;
                    else if (w_lo == 4'h2 || w_lo == 4'h4 ||
                             w_lo == 4'h5)                      o_len = LEN2;
                end
                4'hA: begin
                    if (w_lo == 4'h0 || w_lo == 4'h2 || w_lo >= 4'h6) o_len = LEN2;
                end
                4'hB: begin
                    if (w_lo >= 4'h4)                           o_len = LEN3;
                    else if (w_lo == 4'h0 || w_lo == 4'h2)      o_len = LEN2;
                end
                4'hC: begin
                    if (w_lo == 4'h0 || w_lo == 4'h2 || w_lo == 4'h5) o_len = LEN2;
                end
                4'hD: begin
                    if (w_lo == 4'h5)                           o_len = LEN3;
                    else if (w_lo == 4'h0 || w_lo == 4'h2 ||
                             w_lo >= 4'h8)                      o_len = LEN2;
                end
                default: begin
                    if (w_lo == 4'h5) o_len = LEN2;
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_fetch_unit.sv
// Program-memory fetch unit: drives ROM cs_n/address, assembles 1..3 byte
// MCS-51 instructions, hands them over valid/ready. FETCH_INSTR_CNT_EN adds fetch_cnt.
module prog_fetch_unit
    import mcs51_pkg::*;
#(
    parameter int ADDRWIDTH = 8
) (
    input  logic                 clk,
`ifdef FETCH_INSTR_CNT_EN
    output logic [15:0]          fetch_cnt,
`endif
    input  logic                 rst,
    output logic                 mem_cs_n,
    output logic [ADDRWIDTH-1:0] mem_addr,
    input  logic [7:0]           mem_dout,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [7:0]           instr_op,
    output logic [7:0]           instr_b1,
    output logic [7:0]           instr_b2,
    output logic [1:0]           instr_len,
    output logic [ADDRWIDTH-1:0] instr_pc,
    input  logic                 jmp_en,
    input  logic [ADDRWIDTH-1:0] jmp_addr
);

    fetch_state_t         r_state;
    logic [ADDRWIDTH-1:0] r_pc;
    logic [ADDRWIDTH-1:0] r_addr;
    logic                 r_cs_n;
    logic                 r_valid;
    logic [7:0]           r_op;
    logic [7:0]           r_b1;
    logic [7:0]           r_b2;
    instr_len_t           r_len;
    logic [ADDRWIDTH-1:0] r_ipc;
    logic [1:0]           w_len;
    logic                 w_accept;

    mcs51_len_lut u_len_lut (
        .i_opcode (mem_dout),
        .o_len    (w_len)
    );

    assign w_accept = r_valid & instr_ready & ~jmp_en;

    // r_pc holds the opcode address until the last byte is in, so B1/B2
    // addresses are formed as pc+1/pc+2 and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_addr  <= '0;
            r_cs_n  <= 1'b1;
            r_valid <= 1'b0;
            r_op    <= '0;
            r_b1    <= '0;
            r_b2    <= '0;
            r_len   <= LEN1;
            r_ipc   <= '0;
        end else if (jmp_en) begin
            r_pc    <= jmp_addr;
            r_addr  <= jmp_addr;
            r_cs_n  <= 1'b0;
            r_valid <= 1'b0;
            r_state <= ST_OP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_addr  <= r_pc;
                    r_cs_n  <= 1'b0;
                    r_state <= ST_OP;
                end
                ST_OP: begin
                    r_op  <= mem_dout;
                    r_ipc <= r_pc;
                    r_b1  <= '0;
                    r_b2  <= '0;
                    r_len <= w_len;
                    if (w_len == LEN1) begin
                        r_pc    <= r_pc + ADDRWIDTH'(1);
                        r_cs_n  <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= ST_HOLD;
                    end else begin
                        r_addr  <= r_pc + ADDRWIDTH'(1);
                        r_state <= ST_B1;
                    end
                end
                ST_B1: begin
                    r_b1 <= mem_dout;
                    if (r_len == LEN2) begin
                        r_pc    <= r_pc + ADDRWIDTH'(2);
                        r_cs_n  <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= ST_HOLD;
                    end else begin
                        r_addr  <= r_pc + ADDRWIDTH'(2);
                        r_state <= ST_B2;
                    end
                end
                ST_B2: begin
                    r_b2    <= mem_dout;
                    r_pc    <= r_pc + ADDRWIDTH'(3);
                    r_cs_n  <= 1'b1;
                    r_valid <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_addr  <= r_pc;
                        r_cs_n  <= 1'b0;
                        r_state <= ST_OP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_INSTR_CNT_EN
    logic [15:0] r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
        end else if (w_accept && (r_fetch_cnt != '1)) begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`endif

    assign mem_cs_n    = r_cs_n;
    assign mem_addr    = r_addr;
    assign instr_valid = r_valid;
    assign instr_op    = r_op;
    assign instr_b1    = r_b1;
    assign instr_b2    = r_b2;
    assign instr_len   = r_len;
    assign instr_pc    = r_ipc;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Scoreboard bench for prog_fetch_unit: directed ROM images, expected
// instructions queued by stimulus, checked by a monitor on each handshake.
module tb_prog_fetch_unit;
    import mcs51_pkg::*;

    localparam int AW = 8;

    typedef struct packed {
        logic [7:0]    op;
        logic [7:0]    b1;
        logic [7:0]    b2;
        logic [1:0]    len;
        logic [AW-1:0] pc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_cs_n;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dout = 8'h00;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [7:0]    instr_op;
    logic [7:0]    instr_b1;
    logic [7:0]    instr_b2;
    logic [1:0]    instr_len;
    logic [AW-1:0] instr_pc;
    logic          jmp_en = 1'b0;
    logic [AW-1:0] jmp_addr = '0;
`ifdef FETCH_INSTR_CNT_EN
    logic [15:0]   fetch_cnt;
`endif

    logic [7:0] rom [256];
    exp_t       q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;

    prog_fetch_unit #(.ADDRWIDTH(AW)) dut (
        .clk         (clk),
`ifdef FETCH_INSTR_CNT_EN
        .fetch_cnt   (fetch_cnt),
`endif
        .rst         (rst),
        .mem_cs_n    (mem_cs_n),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_b1    (instr_b1),
        .instr_b2    (instr_b2),
        .instr_len   (instr_len),
        .instr_pc    (instr_pc),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr)
    );

    always #5 clk = ~clk;

    // Byte-wide ROM latching on negedge; bus floats while deselected.
    always @(negedge clk) begin
        if (!mem_cs_n) mem_dout <= rom[mem_addr];
        else           mem_dout <= 'z;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] op, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [1:0] len,
                                input logic [AW-1:0] pc);
        exp_t e;
        e.op = op; e.b1 = b1; e.b2 = b2; e.len = len; e.pc = pc;
        return e;
    endfunction

    // Monitor: every valid cycle must have cs_n deasserted; handshakes pop.
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid) chk("hold_cs_n", 32'(mem_cs_n), 32'd1);
            if (instr_valid && instr_ready && !jmp_en) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got op %0h pc %0h expected none",
                             instr_op, instr_pc);
                end else begin
                    mon_e = q.pop_front();
                    chk("instr_op",  32'(instr_op),  32'(mon_e.op));
                    chk("instr_b1",  32'(instr_b1),  32'(mon_e.b1));
                    chk("instr_b2",  32'(instr_b2),  32'(mon_e.b2));
                    chk("instr_len", 32'(instr_len), 32'(mon_e.len));
                    chk("instr_pc",  32'(instr_pc),  32'(mon_e.pc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        jmp_en = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_cs_n"},  32'(mem_cs_n),    32'd1);
        chk({tag, "_addr"},  32'(mem_addr),    32'd0);
        chk({tag, "_op"},    32'(instr_op),    32'd0);
        chk({tag, "_b1"},    32'(instr_b1),    32'd0);
        chk({tag, "_b2"},    32'(instr_b2),    32'd0);
        chk({tag, "_len"},   32'(instr_len),   32'd1);
        chk({tag, "_pc"},    32'(instr_pc),    32'd0);
    endtask

    task automatic wait_empty(input int maxc, input string name);
        int k = 0;
        while (q.size() != 0 && k < maxc) begin
            tick();
            k++;
        end
        chk({name, "_pending"}, 32'(q.size()), 32'd0);
        instr_ready = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, input string name);
        int k = 0;
        while (!instr_valid && k < maxc) begin
            tick();
            k++;
        end
        chk(name, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming with ready held high
        clear_rom();
        rom[0] = OP_MOV_A_IMM; rom[1] = 8'h55; rom[2] = 8'hF8; rom[3] = 8'hFF;
        do_reset();
        chk_reset_state("rst");
        q.push_back(mk(OP_MOV_A_IMM, 8'h55, 8'h00, 2'd2, 8'h00));
        q.push_back(mk(8'hF8, 8'h00, 8'h00, 2'd1, 8'h02));
        q.push_back(mk(8'hFF, 8'h00, 8'h00, 2'd1, 8'h03));
        q.push_back(mk(OP_NOP, 8'h00, 8'h00, 2'd1, 8'h04));
        instr_ready = 1'b1;
        tick();
        chk("e1_valid", 32'(instr_valid), 32'd0);
        chk("e1_cs_n",  32'(mem_cs_n),    32'd0);
        chk("e1_addr",  32'(mem_addr),    32'd0);
        tick();
        chk("e2_valid", 32'(instr_valid), 32'd0);
        chk("e2_addr",  32'(mem_addr),    32'd1);
        tick();
        chk("e3_valid", 32'(instr_valid), 32'd1);
        wait_empty(40, "stream");
`ifdef FETCH_INSTR_CNT_EN
        chk("stream_cnt", 32'(fetch_cnt), 32'd4);
`endif

        // Backpressure on the two-byte instruction
        do_reset();
        wait_valid(10, "bp_valid");
        for (int c = 0; c < 5; c++) begin
            chk("bp_op",    32'(instr_op),    32'h74);
            chk("bp_b1",    32'(instr_b1),    32'h55);
            chk("bp_len",   32'(instr_len),   32'd2);
            chk("bp_pc",    32'(instr_pc),    32'd0);
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_addr",  32'(mem_addr),    32'd1);
            tick();
        end
        q.push_back(mk(OP_MOV_A_IMM, 8'h55, 8'h00, 2'd2, 8'h00));
        q.push_back(mk(8'hF8, 8'h00, 8'h00, 2'd1, 8'h02));
        instr_ready = 1'b1;
        tick();
        chk("bp_next_addr", 32'(mem_addr),    32'd2);
        chk("bp_next_cs_n", 32'(mem_cs_n),    32'd0);
        chk("bp_next_vld",  32'(instr_valid), 32'd0);
        wait_empty(20, "bp");

        // Jump while fetching the second byte of 74 55
        do_reset();
        instr_ready = 1'b1;
        q.push_back(mk(8'hFF, 8'h00, 8'h00, 2'd1, 8'h03));
        q.push_back(mk(OP_NOP, 8'h00, 8'h00, 2'd1, 8'h04));
        tick();
        tick();
        jmp_en = 1'b1;
        jmp_addr = 8'h03;
        tick();
        jmp_en = 1'b0;
        chk("jb1_valid", 32'(instr_valid), 32'd0);
        chk("jb1_addr",  32'(mem_addr),    32'd3);
        chk("jb1_cs_n",  32'(mem_cs_n),    32'd0);
        wait_empty(20, "jb1");

        // Jump collides with a handshake on a held instruction
        do_reset();
        wait_valid(10, "col_valid");
        q.push_back(mk(8'hFF, 8'h00, 8'h00, 2'd1, 8'h03));
        q.push_back(mk(OP_NOP, 8'h00, 8'h00, 2'd1, 8'h04));
        instr_ready = 1'b1;
        jmp_en = 1'b1;
        jmp_addr = 8'h03;
        tick();
        jmp_en = 1'b0;
        chk("col_valid_after", 32'(instr_valid), 32'd0);
        chk("col_addr",        32'(mem_addr),    32'd3);
`ifdef FETCH_INSTR_CNT_EN
        chk("col_cnt_zero", 32'(fetch_cnt), 32'd0);
`endif
        wait_empty(20, "col");
`ifdef FETCH_INSTR_CNT_EN
        chk("col_cnt_two", 32'(fetch_cnt), 32'd2);
`endif

        // Address wrap: single-byte at FF, then 74 55 at 00
        clear_rom();
        rom[8'hFF] = OP_NOP; rom[0] = OP_MOV_A_IMM; rom[1] = 8'h55;
        do_reset();
        instr_ready = 1'b1;
        jmp_en = 1'b1;
        jmp_addr = 8'hFF;
        q.push_back(mk(OP_NOP, 8'h00, 8'h00, 2'd1, 8'hFF));
        q.push_back(mk(OP_MOV_A_IMM, 8'h55, 8'h00, 2'd2, 8'h00));
        tick();
        jmp_en = 1'b0;
        wait_empty(20, "wrap");

        // Three-byte instruction straddling the wrap (FF,00,01)
        clear_rom();
        rom[8'hFF] = OP_MOV_DIR_IMM; rom[0] = 8'hAA; rom[1] = 8'hBB;
        do_reset();
        instr_ready = 1'b1;
        jmp_en = 1'b1;
        jmp_addr = 8'hFF;
        q.push_back(mk(OP_MOV_DIR_IMM, 8'hAA, 8'hBB, 2'd3, 8'hFF));
        q.push_back(mk(OP_NOP, 8'h00, 8'h00, 2'd1, 8'h02));
        tick();
        jmp_en = 1'b0;
        wait_empty(20, "straddle");

        // Reset during the third byte of an LJMP at 10
        clear_rom();
        rom[0] = OP_MOV_A_IMM; rom[1] = 8'h55;
        rom[8'h10] = OP_LJMP; rom[8'h11] = 8'h12; rom[8'h12] = 8'h34;
        do_reset();
        instr_ready = 1'b1;
        jmp_en = 1'b1;
        jmp_addr = 8'h10;
        tick();
        jmp_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_reset_state("midrst");
        rst = 1'b0;
        q.push_back(mk(OP_MOV_A_IMM, 8'h55, 8'h00, 2'd2, 8'h00));
        wait_empty(20, "midrst");

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
